// File: rtl/correlation_pkg.sv
// Shared definitions for the sliding-correlation scheduler.
//   state_t       : scheduler FSM states
//   DEFAULT_*     : default window / width parameters
//   coef_default  : power-on coefficient for tap k (k+1)
package correlation_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    OUTPUT
  } state_t;

  localparam int unsigned DEFAULT_TAPS = 10;
  localparam int unsigned DEFAULT_XW   = 4;
  localparam int unsigned DEFAULT_CW   = 4;
  localparam int unsigned DEFAULT_YW   = 12;

  function automatic int unsigned coef_default(input int unsigned k);
    return k + 1;
  endfunction

endpackage

// File: rtl/coef_product_unit.sv
// Shared coefficient x sample product resource.
//   coef    in  CW       coefficient of the currently selected tap
//   sample  in  XW       window sample of the currently selected tap
//   product out CW+XW    unsigned product (combinational)
module coef_product_unit #(
  parameter int unsigned CW = 4,
  parameter int unsigned XW = 4
) (
  input  logic [CW-1:0]    coef,
  input  logic [XW-1:0]    sample,
  output logic [CW+XW-1:0] product
);

  always_comb begin
    product = (CW+XW)'(coef) * (CW+XW)'(sample);
  end

endmodule

// File: rtl/correlation_scheduler.sv
// Time-multiplexed 10-tap sliding correlator. One sample is accepted in IDLE,
// then one shared product is accumulated per cycle over all taps, and the sum
// is held on a valid/ready output.
//   clock, reset        single clock, synchronous active-high reset
//   in_valid/in_data    sample input, in_ready high only in IDLE
//   clear               zero the window (IDLE only)
//   coef_we/addr/data   coefficient write port (IDLE only, addr >= TAPS ignored)
//   y_valid/y/y_ready   result output
//   busy                scheduler not idle
module correlation_scheduler
  import correlation_pkg::*;
#(
  parameter int unsigned TAPS = DEFAULT_TAPS,
  parameter int unsigned XW   = DEFAULT_XW,
  parameter int unsigned CW   = DEFAULT_CW,
  parameter int unsigned YW   = DEFAULT_YW
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [XW-1:0] in_data,
  output logic          in_ready,
  input  logic          clear,
  input  logic          coef_we,
  input  logic [3:0]    coef_addr,
  input  logic [CW-1:0] coef_data,
  output logic          y_valid,
  output logic [YW-1:0] y,
  input  logic          y_ready,
  output logic          busy
);

  localparam int unsigned TW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int unsigned PW = XW + CW;

  state_t          state;
  state_t          state_next;
  logic [XW-1:0]   win  [TAPS];
  logic [CW-1:0]   coef [TAPS];
  logic [YW-1:0]   acc;
  logic [TW-1:0]   tap;
  logic [PW-1:0]   product;
  logic            accept;
  logic            last_tap;

  always_comb begin
    accept   = in_valid && (state == IDLE);
    last_tap = (tap == TW'(TAPS - 1));
  end

  coef_product_unit #(
    .CW (CW),
    .XW (XW)
  ) u_product (
    .coef    (coef[tap]),
    .sample  (win[tap]),
    .product (product)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept)   state_next = ACCUM;
      ACCUM:   if (last_tap) state_next = OUTPUT;
      OUTPUT:  if (y_ready)  state_next = IDLE;
      default:               state_next = IDLE;
    endcase
  end

  // Output decode: registered state only, no path from inputs
  always_comb begin
    in_ready = (state == IDLE);
    busy     = (state != IDLE);
    y_valid  = (state == OUTPUT);
    y        = (state == OUTPUT) ? acc : '0;
  end

  // Window, coefficients, accumulator and tap counter
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned k = 0; k < TAPS; k++) begin
        win[k]  <= '0;
        coef[k] <= CW'(coef_default(k));
      end
      acc <= '0;
      tap <= '0;
    end else begin
      case (state)
        IDLE: begin
          // The coefficient register is written at the same edge the sample
          // is accepted, so ACCUM already sees the new value.
          if (coef_we && (32'(coef_addr) < TAPS)) begin
            coef[coef_addr] <= coef_data;
          end
          if (accept) begin
            // Clear with a coincident sample: shift a zeroed window.
            win[0] <= in_data;
            for (int unsigned k = 1; k < TAPS; k++) begin
              win[k] <= clear ? '0 : win[k-1];
            end
            acc <= '0;
            tap <= '0;
          end else if (clear) begin
            for (int unsigned k = 0; k < TAPS; k++) begin
              win[k] <= '0;
            end
          end
        end
        ACCUM: begin
          acc <= acc + YW'(product);
          tap <= last_tap ? '0 : tap + TW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_correlation_scheduler.sv
// Self-checking bench for correlation_scheduler: a reference model computes
// each expected result when the sample is driven and queues it; results are
// popped and compared when the DUT presents them.
module tb_correlation_scheduler;

  localparam int TAPS = 10;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [3:0]  in_data;
  logic        in_ready;
  logic        clear;
  logic        coef_we;
  logic [3:0]  coef_addr;
  logic [3:0]  coef_data;
  logic        y_valid;
  logic [11:0] y;
  logic        y_ready;
  logic        busy;

  int n_compared   = 0;
  int n_mismatched = 0;
  int exp_q[$];
  int win_m  [TAPS];
  int coef_m [TAPS];
  int last_y;

  always #5 clock = ~clock;

  correlation_scheduler #(
    .TAPS (10),
    .XW   (4),
    .CW   (4),
    .YW   (12)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .clear     (clear),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .y_valid   (y_valid),
    .y         (y),
    .y_ready   (y_ready),
    .busy      (busy)
  );

  task automatic check_val(input string tag, input int obs, input int exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    for (int k = 0; k < TAPS; k++) begin
      win_m[k]  = 0;
      coef_m[k] = k + 1;
    end
    exp_q.delete();
  endtask

  task automatic apply_reset();
    reset = 1'b1; in_valid = 1'b0; clear = 1'b0; coef_we = 1'b0; y_ready = 1'b0;
    tick();
    check_val("rst_y_valid",  y_valid,  0);
    check_val("rst_y",        y,        0);
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_busy",     busy,     0);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic write_coef(input int addr, input int data);
    coef_we = 1'b1; coef_addr = 4'(addr); coef_data = 4'(data);
    tick();
    coef_we = 1'b0;
    if (addr < TAPS) coef_m[addr] = data;
  endtask

  // Called just after a clock edge with the DUT in IDLE.
  task automatic run_sample(input int s, input int clr, input int hold,
                            input int we, input int wa, input int wd);
    int lat;
    int e;
    check_val("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; in_data = 4'(s); clear = (clr != 0);
    coef_we = (we != 0); coef_addr = 4'(wa); coef_data = 4'(wd);
    y_ready = (hold == 0);
    if (we != 0 && wa < TAPS) coef_m[wa] = wd;
    if (clr != 0) for (int k = 0; k < TAPS; k++) win_m[k] = 0;
    for (int k = TAPS - 1; k > 0; k--) win_m[k] = win_m[k-1];
    win_m[0] = s;
    e = 0;
    for (int k = 0; k < TAPS; k++) e += coef_m[k] * win_m[k];
    exp_q.push_back(e);
    tick();
    in_valid = 1'b0; clear = 1'b0; coef_we = 1'b0;
    lat = 1;
    while (!y_valid && lat <= 20) begin
      check_val("in_ready_busy", in_ready, 0);
      check_val("busy_accum",    busy,     1);
      tick();
      lat++;
    end
    check_val("latency", lat, 11);
    if (!y_valid) return;
    for (int i = 0; i < hold; i++) begin
      coef_we = 1'b1; coef_addr = 4'd0; coef_data = 4'd15;
      check_val("hold_y_valid",  y_valid,  1);
      check_val("hold_y",        y,        e);
      check_val("hold_in_ready", in_ready, 0);
      tick();
    end
    coef_we = 1'b0; y_ready = 1'b1;
    last_y = int'(y);
    if (exp_q.size() != 0) check_val("y", y, exp_q.pop_front());
    else                   check_val("scoreboard_size", exp_q.size(), 1);
    tick();
    check_val("post_in_ready", in_ready, 1);
    check_val("post_y_valid",  y_valid,  0);
    check_val("post_busy",     busy,     0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; clear = 1'b0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0; y_ready = 1'b0;
    model_reset();
    tick();
    apply_reset();

    // Single sample through default coefficients
    run_sample(1, 0, 0, 0, 0, 0);
    check_val("single_y", last_y, 1);

    // Ten back-to-back samples
    apply_reset();
    for (int s = 1; s <= 10; s++) run_sample(s, 0, 0, 0, 0, 0);
    check_val("sum_220", last_y, 220);

    // Output backpressure with an ignored coefficient write, then defaults persist
    run_sample(4, 0, 5, 0, 0, 0);
    run_sample(2, 0, 0, 0, 0, 0);

    // Clear coincident with a sample on a full window
    apply_reset();
    for (int s = 1; s <= 10; s++) run_sample(s, 0, 0, 0, 0, 0);
    run_sample(5, 1, 0, 0, 0, 0);
    check_val("clear_y", last_y, 5);

    // Maximum coefficients and samples; out-of-range address ignored
    for (int a = 0; a < TAPS; a++) write_coef(a, 15);
    write_coef(12, 3);
    for (int i = 0; i < 10; i++) run_sample(15, 0, 0, 0, 0, 0);
    check_val("max_2250", last_y, 2250);

    // Coefficient write coincident with a sample
    run_sample(3, 0, 0, 1, 0, 2);

    // Reset during the 4th ACCUM cycle
    check_val("mid_in_ready", in_ready, 1);
    in_valid = 1'b1; in_data = 4'd7; y_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    check_val("mid_busy_pre", busy, 1);
    reset = 1'b1;
    tick();
    check_val("mid_y_valid",  y_valid,  0);
    check_val("mid_busy",     busy,     0);
    check_val("mid_in_ready2", in_ready, 1);
    reset = 1'b0;
    model_reset();
    run_sample(3, 0, 0, 0, 0, 0);
    check_val("post_reset_y", last_y, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
